dma_multichannel_csr: RTL

- Parametrised, multi-channel successor to the single-channel DMA register map.
- Holds per-channel ISR/IFCR/CCR/CNDTR/CPAR/CMAR state behind one CSR port.
- Owns the live transfer counter, with half-transfer, transfer-complete and error flag generation, circular reload and per-channel interrupts.
- Sits between the host CSR bus and the DMA transfer engines, one engine per channel.

---
 rtl/dma_multichannel_csr.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/dma_multichannel_csr.sv
// ---------------------------------------------------------------------------
// dma_multichannel_csr
//
// Register map and channel bookkeeping for a CH_CNT-channel DMA controller.
// Each channel has its own CCR/CNDTR/CPAR/CMAR registers, a live transfer
// counter with a reload shadow for circular mode, the TCIF/HTIF/TEIF flags,
// and a registered interrupt line. All channels share one CSR port.
//
// CSR address = {channel, reg index}
//   0 ISR   (RO)  {28'b0, TEIF, HTIF, TCIF, GIF}
//   1 IFCR  (WO)  write-1-to-clear: bit0 CGIF, bit1 CTCIF, bit2 CHTIF, bit3 CTEIF
//   2 CCR   (RW)  bit0 EN, bit1 TCIE, bit2 HTIE, bit3 TEIE, bit5 CIRC, [14:0] stored
//   3 CNDTR (RW)  reads the live count; a write loads count and reload shadow
//   4 CPAR  (RW)  peripheral address
//   5 CMAR  (RW)  memory address
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   csr_*                   host register port, 1-cycle read latency
//   ch_ccr_o/ndt_o/par_o/mar_o  per-channel configuration to the engines
//   xfer_done_i/xfer_err_i  per-channel single-cycle engine events
//   irq_o, irq_any_o        registered interrupts
// ---------------------------------------------------------------------------
module dma_multichannel_csr #(
  parameter  int CH_CNT = 4,
  parameter  int NDT_W  = 16,
  localparam int CH_W   = (CH_CNT > 1) ? $clog2(CH_CNT) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CH_W+2:0]       csr_address_i,
  input  logic                  csr_write_i,
  input  logic [31:0]           csr_writedata_i,
  input  logic                  csr_read_i,
  output logic [31:0]           csr_readdata_o,
  output logic                  csr_readdatavalid_o,
  output logic [CH_CNT*15-1:0]  ch_ccr_o,
  output logic [CH_CNT*NDT_W-1:0] ch_ndt_o,
  output logic [CH_CNT*32-1:0]  ch_par_o,
  output logic [CH_CNT*32-1:0]  ch_mar_o,
  input  logic [CH_CNT-1:0]     xfer_done_i,
  input  logic [CH_CNT-1:0]     xfer_err_i,
  output logic [CH_CNT-1:0]     irq_o,
  output logic                  irq_any_o
);

  localparam logic [2:0] REG_ISR   = 3'd0;
  localparam logic [2:0] REG_IFCR  = 3'd1;
  localparam logic [2:0] REG_CCR   = 3'd2;
  localparam logic [2:0] REG_CNDTR = 3'd3;
  localparam logic [2:0] REG_CPAR  = 3'd4;
  localparam logic [2:0] REG_CMAR  = 3'd5;

  localparam int CCR_EN   = 0;
  localparam int CCR_TCIE = 1;
  localparam int CCR_HTIE = 2;
  localparam int CCR_TEIE = 3;
  localparam int CCR_CIRC = 5;

  // Per-channel state and next-state
  logic [14:0]      ccr_q  [CH_CNT];
  logic [14:0]      ccr_d  [CH_CNT];
  logic [NDT_W-1:0] cnt_q  [CH_CNT];
  logic [NDT_W-1:0] cnt_d  [CH_CNT];
  logic [NDT_W-1:0] rld_q  [CH_CNT];
  logic [NDT_W-1:0] rld_d  [CH_CNT];
  logic [31:0]      par_q  [CH_CNT];
  logic [31:0]      par_d  [CH_CNT];
  logic [31:0]      mar_q  [CH_CNT];
  logic [31:0]      mar_d  [CH_CNT];
  logic [CH_CNT-1:0] tcif_q, tcif_d;
  logic [CH_CNT-1:0] htif_q, htif_d;
  logic [CH_CNT-1:0] teif_q, teif_d;
  logic [CH_CNT-1:0] irq_d;

  // Address decode, shared by reads and writes
  logic [CH_W-1:0] addr_ch;
  logic [2:0]      addr_idx;
  logic            addr_ch_ok;
  logic [31:0]     rd_data;

  assign addr_ch    = csr_address_i[CH_W+2:3];
  assign addr_idx   = csr_address_i[2:0];
  assign addr_ch_ok = (int'(addr_ch) < CH_CNT);

  // -------------------------------------------------------------------------
  // Next-state: CSR writes, engine events, flag set/clear, interrupt terms
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a default before any conditional assignment so
    // no path leaves a variable unassigned, which would infer a latch.
    ccr_d  = ccr_q;
    cnt_d  = cnt_q;
    rld_d  = rld_q;
    par_d  = par_q;
    mar_d  = mar_q;
    tcif_d = tcif_q;
    htif_d = htif_q;
    teif_d = teif_q;
    irq_d  = '0;

    for (int c = 0; c < CH_CNT; c++) begin : g_ch_next
      logic             sel;
      logic             en;
      logic             tc_set;
      logic             ht_set;
      logic             te_set;
      logic [3:0]       clr;
      logic [NDT_W-1:0] cnt_nxt;

      sel     = csr_write_i && addr_ch_ok && (addr_ch == CH_W'(c));
      en      = ccr_q[c][CCR_EN];
      tc_set  = 1'b0;
      ht_set  = 1'b0;
      te_set  = 1'b0;
      clr     = 4'b0;
      cnt_nxt = cnt_q[c] - NDT_W'(1);

      if (sel) begin
        case (addr_idx)
          REG_IFCR: clr = csr_writedata_i[3:0];
          REG_CCR: begin
            if (en) begin
              // Running channel: configuration is frozen, only EN may change.
              ccr_d[c][CCR_EN] = csr_writedata_i[CCR_EN];
            end else begin
              ccr_d[c] = csr_writedata_i[14:0];
              // Nothing to transfer: refuse to start.
              if (cnt_q[c] == '0) ccr_d[c][CCR_EN] = 1'b0;
            end
          end
          REG_CNDTR: if (!en) begin
            cnt_d[c] = csr_writedata_i[NDT_W-1:0];
            rld_d[c] = csr_writedata_i[NDT_W-1:0];
          end
          REG_CPAR: if (!en) par_d[c] = csr_writedata_i;
          REG_CMAR: if (!en) mar_d[c] = csr_writedata_i;
          default: ;
        endcase
      end

      // An error aborts the channel and swallows a coincident done pulse.
      // Engine-side EN clears take priority over a coincident CCR write.
      if (en && xfer_err_i[c]) begin
        te_set           = 1'b1;
        ccr_d[c][CCR_EN] = 1'b0;
      end else if (en && xfer_done_i[c] && (cnt_q[c] != '0)) begin
        cnt_d[c] = cnt_nxt;
        if (cnt_nxt == (rld_q[c] >> 1)) ht_set = 1'b1;
        if (cnt_nxt == '0) begin
          tc_set = 1'b1;
          if (ccr_q[c][CCR_CIRC]) cnt_d[c] = rld_q[c];
          else                    ccr_d[c][CCR_EN] = 1'b0;
        end
      end

      // Set wins over a same-cycle clear.
      tcif_d[c] = (tcif_q[c] & ~(clr[0] | clr[1])) | tc_set;
      htif_d[c] = (htif_q[c] & ~(clr[0] | clr[2])) | ht_set;
      teif_d[c] = (teif_q[c] & ~(clr[0] | clr[3])) | te_set;

      irq_d[c] = (tcif_d[c] & ccr_d[c][CCR_TCIE]) |
                 (htif_d[c] & ccr_d[c][CCR_HTIE]) |
                 (teif_d[c] & ccr_d[c][CCR_TEIE]);
    end
  end

  // -------------------------------------------------------------------------
  // Read mux (current state, so a same-cycle write is not visible yet)
  // -------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    if (addr_ch_ok) begin
      case (addr_idx)
        REG_ISR: rd_data = {28'b0, teif_q[addr_ch], htif_q[addr_ch], tcif_q[addr_ch],
                            tcif_q[addr_ch] | htif_q[addr_ch] | teif_q[addr_ch]};
        REG_CCR:   rd_data = {17'b0, ccr_q[addr_ch]};
        REG_CNDTR: rd_data = {{(32-NDT_W){1'b0}}, cnt_q[addr_ch]};
        REG_CPAR:  rd_data = par_q[addr_ch];
        REG_CMAR:  rd_data = mar_q[addr_ch];
        default:   rd_data = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the per-channel arrays are real flops that must start cleared,
      // so they are reset explicitly here rather than left uninitialised.
      ccr_q               <= '{default: '0};
      cnt_q               <= '{default: '0};
      rld_q               <= '{default: '0};
      par_q               <= '{default: '0};
      mar_q               <= '{default: '0};
      tcif_q              <= '0;
      htif_q              <= '0;
      teif_q              <= '0;
      irq_o               <= '0;
      irq_any_o           <= 1'b0;
      csr_readdata_o      <= '0;
      csr_readdatavalid_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      ccr_q               <= ccr_d;
      cnt_q               <= cnt_d;
      rld_q               <= rld_d;
      par_q               <= par_d;
      mar_q               <= mar_d;
      tcif_q              <= tcif_d;
      htif_q              <= htif_d;
      teif_q              <= teif_d;
      irq_o               <= irq_d;
      irq_any_o           <= |irq_d;
      csr_readdata_o      <= csr_read_i ? rd_data : '0;
      csr_readdatavalid_o <= csr_read_i;
    end
  end

  // Flatten per-channel configuration onto the engine-facing buses
  always_comb begin
    ch_ccr_o = '0;
    ch_ndt_o = '0;
    ch_par_o = '0;
    ch_mar_o = '0;
    for (int c = 0; c < CH_CNT; c++) begin
      ch_ccr_o[c*15 +: 15]       = ccr_q[c];
      ch_ndt_o[c*NDT_W +: NDT_W] = cnt_q[c];
      ch_par_o[c*32 +: 32]       = par_q[c];
      ch_mar_o[c*32 +: 32]       = mar_q[c];
    end
  end

endmodule
